uart_tx_feeder: RTL and testbench
=================================

// Module: uart_tx_feeder
// PURPOSE
//  Byte FIFO plus sequencer that sits directly upstream of the serial transmitter.
//  Producers push bytes at clock rate, and this block hands them one at a time to
//  the transmitter through its start/data/ready handshake.
//  Decouples bursty writers (message generators, echo loops) from the slow baud-rate drain.
// PARAMETERS
//  AW  4  FIFO address width; depth = 2**AW bytes (16)
// PORTS
//  clk       in   1     system clock; all logic is single-clock, rising edge
//  rst       in   1     synchronous, active-high reset
//  wr_en     in   1     push wr_data this cycle (ignored while full)
//  wr_data   in   8     byte to enqueue
//  full      out  1     FIFO holds 2**AW bytes
//  empty     out  1     FIFO holds 0 bytes
//  count     out  AW+1  current occupancy, 0..2**AW
//  overflow  out  1     sticky: a push was attempted while full
//  tx_start  out  1     one-cycle start pulse to the transmitter
//  tx_data   out  8     byte to send; stable from the tx_start cycle until the next pop
//  tx_ready  in   1     transmitter idle (1) / busy (0); combinational from transmitter state
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - rd_ptr=wr_ptr=0, count=0, so empty=1 and full=0.
//   - overflow=0, state=IDLE, tx_start=0, tx_data=8'h00.
//   - FIFO memory contents are not reset.
//  Push:
//   - wr_en & !full: mem[wr_ptr] <= wr_data, wr_ptr++ (wraps mod 2**AW).
//   - wr_en & full: byte dropped, overflow <= 1. This holds even if a pop occurs in the same cycle.
//   - full, empty and count come from registered count only; no same-cycle bypass.
//  Pop: only in IDLE. tx_data <= mem[rd_ptr], rd_ptr++ (wraps).
//  count arithmetic:
//   - push only: count+1; pop only: count-1.
//   - push and pop together: count unchanged.
//   - count never exceeds 2**AW and never goes below 0.
//  FSM (state register, 2 bits):
//   - IDLE: if !empty & tx_ready -> pop, go to SEND. Otherwise stay.
//   - SEND: tx_start=1 for exactly this cycle; go to WAIT_BUSY.
//   - WAIT_BUSY: wait for tx_ready==0 (the transmitter has accepted the byte) -> WAIT_DONE.
//     tx_start=0.
//   - WAIT_DONE: wait for tx_ready==1 (stop bit finished) -> IDLE.
//  tx_start is a decode of state==SEND (registered state, no input path), so it is glitch-free.
//  The transmitter latches tx_data on the SEND cycle edge; tx_data must not change
//  before WAIT_BUSY.
//  Latency, best case: wr_en in cycle N into an empty FIFO with state IDLE and tx_ready=1
//   - pop in N+1, tx_start=1 in N+2.
//  Back-to-back bytes:
//   - next pop occurs in the first cycle tx_ready is seen 1 in WAIT_DONE+IDLE,
//     i.e. 1 cycle after ready rises.
//   - tx_start for the next byte follows 1 cycle after that pop.
//  Never issues tx_start while tx_ready=0. Never issues two starts without observing
//  tx_ready fall then rise in between.
//  Reset mid-transmission:
//   - feeder returns to IDLE and the FIFO is emptied; the transmitter itself finishes its frame.
//   - the IDLE tx_ready guard ensures no start is issued until that frame completes.
//  overflow clears only on rst.
// STRUCTURE
//  Sub-module fifo_sync (#(AW), DW=8):
//   - ports: clk, rst, wr_en, wr_data, rd_en, rd_data, full, empty, count.
//   - registered rd_data, i.e. data valid the cycle after rd_en.
//   - the FSM's tx_data register captures rd_data one cycle after rd_en, which puts
//     SEND one cycle after the pop and makes this capture fit.
//  FSM state localparams (IDLE=0, SEND=1, WAIT_BUSY=2, WAIT_DONE=3) go in shared header
//  uart_feeder.vh, alongside the existing baudgen.vh constants.
// TESTING  (bench uses a behavioural transmitter model or the real transmitter at a fast divisor)
//  1. Reset, then push 8'h41 with tx_ready=1 -> tx_start pulses 1 cycle, 2 cycles after push,
//     with tx_data=8'h41; count returns to 0.
//  2. Push "HOLA" (4 bytes) in 4 consecutive cycles -> exactly 4 tx_start pulses in order
//     48,4F,4C,41; each pulse only after tx_ready rises; none while tx_ready=0.
//  3. Hold tx_ready=0 and push 17 bytes (AW=4):
//     - full=1 and count=16 after the 16th push; the 17th push is dropped and overflow=1.
//     - releasing tx_ready drains exactly the first 16 bytes.
//  4. With count=16, raise tx_ready so a pop coincides with wr_en:
//     - the write is still dropped and count=15.
//     - a push next cycle is accepted and count=16.
//  5. Wrap: push and drain 40 bytes with values 0..39 -> pointers wrap twice and the
//     output sequence is identical to the input.
//  6. Assert rst during WAIT_DONE with 3 bytes queued:
//     - count=0, overflow=0, tx_start=0 the next cycle.
//     - the next tx_start occurs only after the model's tx_ready returns to 1.

Source files
------------

// File: rtl/uart_tx_feeder_pkg.sv
// rtl/uart_tx_feeder_pkg.sv - shared types and constants for the UART transmit feeder
package uart_tx_feeder_pkg;

  localparam int DW = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/uart_tx_feeder_fifo_sync.sv
// rtl/uart_tx_feeder_fifo_sync.sv - single-clock byte FIFO with registered read data
module fifo_sync
  import uart_tx_feeder_pkg::*;
#(
  parameter int AW = 4,
  parameter int W  = DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO plus start/ready sequencer feeding the serial transmitter
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          tx_start,
  output logic [DW-1:0] tx_data,
  input  logic          tx_ready
);

  feeder_state_t state;
  feeder_state_t state_nxt;
  logic          rd_en;

  // The FIFO read register doubles as tx_data: loaded on the pop edge,
  // valid throughout SEND and held until the next pop.
  fifo_sync #(.AW(AW), .W(DW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (tx_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  assign tx_start = (state == SEND);

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && tx_ready) begin
          rd_en     = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND:      state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (!tx_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: if (tx_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - scoreboard bench for uart_tx_feeder with a behavioural transmitter
module tb_uart_tx_feeder;

  localparam int FRAME = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_ready;

  logic       hold;
  int         busy_cnt;

  logic [7:0] sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         starts = 0;
  bit         started_once = 0;
  bit         seen_low = 0;

  uart_tx_feeder #(.AW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for FRAME cycles after a start, unaffected by feeder reset.
  assign tx_ready = (busy_cnt == 0) && !hold;

  always @(posedge clk) begin
    if (tx_start) busy_cnt <= FRAME;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every start must carry the next expected byte under the handshake rules.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (!rst) begin
      if (tx_start) begin
        starts++;
        chk("start_while_ready", {31'd0, tx_ready}, 32'd1);
        if (started_once) chk("ready_fell_between_starts", {31'd0, seen_low}, 32'd1);
        started_once = 1;
        seen_low = 0;
        exp = (sb_q.size() != 0) ? {24'd0, sb_q.pop_front()} : 32'hDEAD;
        chk("tx_data", {24'd0, tx_data}, exp);
      end else if (!tx_ready) begin
        seen_low = 1;
      end
    end
  end

  task automatic push(input logic [7:0] b, input bit expect_sent);
    if (expect_sent) sb_q.push_back(b);
    wr_en   = 1'b1;
    wr_data = b;
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!(sb_q.size() == 0 && empty && tx_ready) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_drain_timeout"}, {31'd0, n >= 1000}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] hola [4];
    hola[0] = 8'h48; hola[1] = 8'h4F; hola[2] = 8'h4C; hola[3] = 8'h41;
    busy_cnt = 0;
    hold     = 1'b0;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_empty",    {31'd0, empty},    32'd1);
    chk("rst_full",     {31'd0, full},     32'd0);
    chk("rst_count",    {27'd0, count},    32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data",  {24'd0, tx_data},  32'd0);

    // Single byte, best-case latency
    push(8'h41, 1);
    @(negedge clk);
    chk("lat_no_start_n1", {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    chk("lat_start_n2", {31'd0, tx_start}, 32'd1);
    chk("lat_data_n2",  {24'd0, tx_data},  32'h41);
    wait_drain("t1");
    chk("t1_count_zero", {27'd0, count}, 32'd0);

    // Burst "HOLA"
    for (int i = 0; i < 4; i++) push(hola[i], 1);
    wait_drain("t2");
    chk("t2_starts", starts, 32'd5);

    // Wrap: 40 sequential values
    for (int i = 0; i < 40; i++) begin
      while (full) begin
        @(posedge clk); #1;
      end
      push(8'(i), 1);
    end
    wait_drain("t5");
    chk("t5_starts", starts, 32'd45);
    chk("t5_overflow", {31'd0, overflow}, 32'd0);

    // Fill with transmitter held busy, overflow on the 17th
    hold = 1'b1;
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i), 1);
    chk("t3_full",  {31'd0, full},  32'd1);
    chk("t3_count", {27'd0, count}, 32'd16);
    chk("t3_no_ovf_yet", {31'd0, overflow}, 32'd0);
    push(8'hEE, 0);
    chk("t3_overflow", {31'd0, overflow}, 32'd1);
    chk("t3_count_17", {27'd0, count}, 32'd16);

    // Pop coinciding with a push while full: push still dropped
    hold = 1'b0;
    push(8'hED, 0);
    chk("t4_count_15", {27'd0, count}, 32'd15);
    push(8'hEF, 1);
    chk("t4_count_16", {27'd0, count}, 32'd16);
    wait_drain("t3");
    chk("t3_starts", starts, 32'd62);
    chk("t3_overflow_sticky", {31'd0, overflow}, 32'd1);

    // Reset during WAIT_DONE with bytes queued
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), 1);
    begin
      int n;
      n = 0;
      while (sb_q.size() != 3 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      chk("t6_first_start_timeout", {31'd0, n >= 100}, 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("t6_count_before_rst", {27'd0, count}, 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    chk("t6_count",    {27'd0, count},    32'd0);
    chk("t6_overflow", {31'd0, overflow}, 32'd0);
    chk("t6_tx_start", {31'd0, tx_start}, 32'd0);
    chk("t6_empty",    {31'd0, empty},    32'd1);
    chk("t6_model_busy", {31'd0, tx_ready}, 32'd0);
    push(8'hB5, 1);
    wait_drain("t6");
    chk("t6_starts", starts, 32'd64);
    chk("final_empty", {31'd0, empty}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
